axi4_burst_slave_mem: RTL and testbench

AXI4 full-protocol slave (responder) backed by a register-file memory. It accepts INCR and FIXED write/read bursts from an AXI master and serves as the S00_AXI endpoint that VIP master benches and PS masters exercise. Write and read channels are independent, each with one outstanding transaction.

---
 rtl/axi4_burst_slave_mem_if.sv | 46 ++++
 rtl/axi4_burst_slave_mem.sv | 194 +++++++++++++++++++
 tb/tb_axi4_burst_slave_mem.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_slave_mem_if.sv
// AXI4 full-protocol bundle used between a burst master and axi4_burst_slave_mem.
// Clock and reset are carried as plain ports alongside this interface.
interface axi4_burst_slave_mem_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 7
);
  logic [C_ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]                AWLEN;
  logic [1:0]                AWBURST;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [C_DATA_WIDTH-1:0]   WDATA;
  logic [C_DATA_WIDTH/8-1:0] WSTRB;
  logic                      WLAST;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [C_ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]                ARLEN;
  logic [1:0]                ARBURST;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [C_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                RRESP;
  logic                      RLAST;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWADDR, AWLEN, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARLEN, ARBURST, ARVALID, input ARREADY,
    input RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWLEN, AWBURST, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARLEN, ARBURST, ARVALID, output ARREADY,
    output RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 burst slave backed by a register-file memory; INCR and FIXED bursts,
// independent write and read channels with one outstanding transaction each.
module axi4_burst_slave_mem #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 7
) (
  input logic                    ACLK,
  input logic                    ARESET,
  axi4_burst_slave_mem_if.slave  s_axi
);
  localparam int BYTES = C_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = C_ADDR_WIDTH - LSB;
  localparam int DEPTH = 2 ** IDX_W;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [C_DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t          w_state;
  logic [IDX_W-1:0]  w_idx;
  logic [7:0]        w_len;
  logic [7:0]        w_beat;
  logic [1:0]        w_burst;
  logic              w_err;
  logic              awready;
  logic              wready;
  logic              bvalid;
  logic [1:0]        bresp;

  r_state_t                r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [7:0]              r_len;
  logic [7:0]              r_beat;
  logic [1:0]              r_burst;
  logic                    arready;
  logic                    rvalid;
  logic                    rlast;
  logic [1:0]              rresp;
  logic [C_DATA_WIDTH-1:0] rdata;

  logic             w_supported;
  logic             w_fire;
  logic             w_last_beat;
  logic             w_mismatch;
  logic [IDX_W-1:0] w_step;
  logic             ar_supported;
  logic [IDX_W-1:0] ar_idx;
  logic [IDX_W-1:0] ar_step;
  logic             r_supported;
  logic [IDX_W-1:0] r_step;
  logic             unused_addr_bits;

  assign w_supported  = (w_burst == BURST_FIXED) || (w_burst == BURST_INCR);
  assign w_fire       = wready && s_axi.WVALID;
  assign w_last_beat  = (w_beat == w_len);
  assign w_mismatch   = (s_axi.WLAST != w_last_beat);
  assign w_step       = IDX_W'(w_burst == BURST_INCR);
  assign ar_supported = (s_axi.ARBURST == BURST_FIXED) || (s_axi.ARBURST == BURST_INCR);
  assign ar_idx       = s_axi.ARADDR[C_ADDR_WIDTH-1:LSB];
  assign ar_step      = IDX_W'(s_axi.ARBURST == BURST_INCR);
  assign r_supported  = (r_burst == BURST_FIXED) || (r_burst == BURST_INCR);
  assign r_step       = IDX_W'(r_burst == BURST_INCR);
  assign unused_addr_bits = ^{s_axi.AWADDR[LSB-1:0], s_axi.ARADDR[LSB-1:0]};

  assign s_axi.AWREADY = awready;
  assign s_axi.WREADY  = wready;
  assign s_axi.BVALID  = bvalid;
  assign s_axi.BRESP   = bresp;
  assign s_axi.ARREADY = arready;
  assign s_axi.RVALID  = rvalid;
  assign s_axi.RLAST   = rlast;
  assign s_axi.RRESP   = rresp;
  assign s_axi.RDATA   = rdata;

  // Memory is never reset; unsupported bursts still consume beats but never write.
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_fire && w_supported) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi.WSTRB[b]) mem[w_idx][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_burst <= BURST_FIXED;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awready && s_axi.AWVALID) begin
            w_idx   <= s_axi.AWADDR[C_ADDR_WIDTH-1:LSB];
            w_len   <= s_axi.AWLEN;
            w_burst <= s_axi.AWBURST;
            w_beat  <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_err <= w_err | w_mismatch;
            if (w_last_beat) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || w_mismatch || !w_supported) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_beat <= w_beat + 8'd1;
              w_idx  <= w_idx + w_step;
            end
          end
        end
        W_RESP: begin
          if (s_axi.BREADY) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // r_idx always points at the word the next beat will fetch, so each beat
  // samples the memory before any same-edge write lands.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_burst <= BURST_FIXED;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arready && s_axi.ARVALID) begin
            r_len   <= s_axi.ARLEN;
            r_burst <= s_axi.ARBURST;
            r_beat  <= '0;
            r_idx   <= ar_idx + ar_step;
            rdata   <= ar_supported ? mem[ar_idx] : '0;
            rresp   <= ar_supported ? RESP_OKAY : RESP_SLVERR;
            rlast   <= (s_axi.ARLEN == 8'd0);
            rvalid  <= 1'b1;
            arready <= 1'b0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && s_axi.RREADY) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              rdata  <= r_supported ? mem[r_idx] : '0;
              rlast  <= ((r_beat + 8'd1) == r_len);
              r_beat <= r_beat + 8'd1;
              r_idx  <= r_idx + r_step;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// Self-checking bench for axi4_burst_slave_mem: directed table, corner sequences
// and random bursts compared against a word-array model of the memory.
module tb_axi4_burst_slave_mem;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  axi4_burst_slave_mem_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(7)) bus ();

  axi4_burst_slave_mem #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(7)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .s_axi  (bus)
  );

  typedef struct {
    string       name;
    logic [6:0]  addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] base;
    int          wlast_beat;
    logic [1:0]  exp_bresp;
    logic [6:0]  chk_addr;
    logic [31:0] exp_word;
  } vec_t;

  int tests = 0;
  int failures = 0;

  logic [31:0] model_mem [32];
  logic [31:0] wbeats [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  int          rd_count;
  vec_t        vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    tests++;
    failures++;
    $display("[TB] FAIL %s: handshake timed out", name);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Memory model: plain word array, byte lanes merged under the strobe.
  task automatic model_write(input logic [6:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] strb, input int wlast_beat, output logic [1:0] resp);
    int idx;
    bit ok;
    ok = (burst == 2'b00) || (burst == 2'b01);
    for (int i = 0; i <= int'(len); i++) begin
      idx = (int'(addr) / 4 + ((burst == 2'b01) ? i : 0)) % 32;
      if (ok) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model_mem[idx][8*b +: 8] = wbeats[i][8*b +: 8];
      end
    end
    resp = (!ok || wlast_beat != int'(len)) ? 2'b10 : 2'b00;
  endtask

  task automatic write_burst(input logic [6:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] strb, input int wlast_beat, output logic [1:0] resp);
    int cnt;
    resp = 2'bxx;
    bus.AWADDR = addr; bus.AWLEN = len; bus.AWBURST = burst; bus.AWVALID = 1'b1;
    cnt = 0;
    while (!bus.AWREADY && cnt < 50) begin step(); cnt++; end
    if (cnt >= 50) report_timeout("aw_handshake");
    step();
    bus.AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.WDATA = wbeats[i]; bus.WSTRB = strb; bus.WLAST = (i == wlast_beat); bus.WVALID = 1'b1;
      cnt = 0;
      while (!bus.WREADY && cnt < 50) begin step(); cnt++; end
      if (cnt >= 50) report_timeout("w_handshake");
      step();
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    bus.BREADY = 1'b1;
    cnt = 0;
    while (!bus.BVALID && cnt < 50) begin step(); cnt++; end
    if (cnt >= 50) report_timeout("b_handshake");
    resp = bus.BRESP;
    step();
    bus.BREADY = 1'b0;
  endtask

  // mode 0: RREADY held high, 1: toggles every cycle, 2: random back-pressure.
  task automatic read_burst(input logic [6:0] addr, input logic [7:0] len, input logic [1:0] burst, input int mode);
    int cnt;
    bit done, held, rr;
    logic [31:0] held_data;
    logic held_last;
    rd_count = 0; done = 0; held = 0;
    bus.ARADDR = addr; bus.ARLEN = len; bus.ARBURST = burst; bus.ARVALID = 1'b1;
    cnt = 0;
    while (!bus.ARREADY && cnt < 50) begin step(); cnt++; end
    if (cnt >= 50) report_timeout("ar_handshake");
    step();
    bus.ARVALID = 1'b0;
    cnt = 0;
    while (!done && cnt < 700) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? cnt[0] : 1'($urandom_range(0, 1));
      bus.RREADY = rr;
      if (bus.RVALID) begin
        if (held) begin
          checkOutput("stall_rdata", bus.RDATA, held_data);
          checkOutput("stall_rlast", 32'(bus.RLAST), 32'(held_last));
        end
        if (rr) begin
          rd_data[rd_count] = bus.RDATA; rd_resp[rd_count] = bus.RRESP; rd_last[rd_count] = bus.RLAST;
          rd_count++;
          held = 0;
          if (bus.RLAST || rd_count == 256) done = 1;
        end else begin
          held = 1; held_data = bus.RDATA; held_last = bus.RLAST;
        end
      end
      step();
      cnt++;
    end
    bus.RREADY = 1'b0;
    if (!done) report_timeout("r_burst");
  endtask

  task automatic check_read(input string name, input logic [6:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int idx;
    bit ok;
    logic [31:0] exp;
    ok = (burst == 2'b00) || (burst == 2'b01);
    checkOutput({name, "_beats"}, 32'(rd_count), 32'(int'(len) + 1));
    for (int i = 0; i < rd_count && i <= int'(len); i++) begin
      idx = (int'(addr) / 4 + ((burst == 2'b01) ? i : 0)) % 32;
      exp = ok ? model_mem[idx] : 32'h0;
      checkOutput($sformatf("%s_data%0d", name, i), rd_data[i], exp);
      checkOutput($sformatf("%s_resp%0d", name, i), 32'(rd_resp[i]), ok ? 32'h0 : 32'h2);
      checkOutput($sformatf("%s_last%0d", name, i), 32'(rd_last[i]), 32'(i == int'(len)));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [1:0] resp, mresp;
    for (int i = 0; i <= int'(v.len); i++) wbeats[i] = v.base + 32'(i);
    write_burst(v.addr, v.len, v.burst, v.strb, v.wlast_beat, resp);
    model_write(v.addr, v.len, v.burst, v.strb, v.wlast_beat, mresp);
    checkOutput({v.name, "_bresp"}, 32'(resp), 32'(v.exp_bresp));
    read_burst(v.chk_addr, 8'd0, 2'b01, 0);
    checkOutput({v.name, "_word"}, rd_data[0], v.exp_word);
    read_burst(v.addr, v.len, v.burst, 0);
    check_read(v.name, v.addr, v.len, v.burst);
  endtask

  initial begin
    logic [1:0] resp, mresp;
    logic [6:0] a;
    logic [7:0] l;
    logic [1:0] bt;
    logic [3:0] s;
    int wb, n, cnt;

    vecs[0] = '{"incr8",       7'h00, 8'd7, 2'b01, 4'hF, 32'd1,          7, 2'b00, 7'h1C, 32'd8};
    vecs[1] = '{"full_word",   7'h10, 8'd0, 2'b01, 4'hF, 32'h11223344,   0, 2'b00, 7'h10, 32'h11223344};
    vecs[2] = '{"strb_0101",   7'h10, 8'd0, 2'b01, 4'h5, 32'hAABBCCDD,   0, 2'b00, 7'h10, 32'h11BB33DD};
    vecs[3] = '{"fixed4",      7'h20, 8'd3, 2'b00, 4'hF, 32'd5,          3, 2'b00, 7'h20, 32'd8};
    vecs[4] = '{"incr_wrap",   7'h78, 8'd3, 2'b01, 4'hF, 32'h100,        3, 2'b00, 7'h04, 32'h103};
    vecs[5] = '{"bad_burst",   7'h40, 8'd0, 2'b10, 4'hF, 32'hDEAD,       0, 2'b10, 7'h40, 32'hC0DE0010};
    vecs[6] = '{"early_wlast", 7'h50, 8'd3, 2'b01, 4'hF, 32'h200,        2, 2'b10, 7'h5C, 32'h203};

    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    ARESET = 1'b1;
    repeat (3) step();
    checkOutput("rst_awready", 32'(bus.AWREADY), 32'h0);
    checkOutput("rst_arready", 32'(bus.ARREADY), 32'h0);
    checkOutput("rst_wready",  32'(bus.WREADY),  32'h0);
    checkOutput("rst_bvalid",  32'(bus.BVALID),  32'h0);
    checkOutput("rst_rvalid",  32'(bus.RVALID),  32'h0);
    checkOutput("rst_rlast",   32'(bus.RLAST),   32'h0);
    checkOutput("rst_rdata",   bus.RDATA,        32'h0);
    ARESET = 1'b0;
    step();
    checkOutput("idle_awready", 32'(bus.AWREADY), 32'h1);
    checkOutput("idle_arready", 32'(bus.ARREADY), 32'h1);

    for (int i = 0; i < 32; i++) wbeats[i] = 32'hC0DE0000 + 32'(i);
    write_burst(7'h00, 8'd31, 2'b01, 4'hF, 31, resp);
    model_write(7'h00, 8'd31, 2'b01, 4'hF, 31, mresp);
    checkOutput("init_bresp", 32'(resp), 32'h0);

    for (int k = 0; k < 7; k++) applyStimulus(vecs[k]);

    // Stalled read: RDATA/RLAST must hold while RREADY is low.
    read_burst(7'h00, 8'd7, 2'b01, 1);
    check_read("stall_rd", 7'h00, 8'd7, 2'b01);
    checkOutput("post_last_rvalid", 32'(bus.RVALID), 32'h0);
    checkOutput("post_last_arready", 32'(bus.ARREADY), 32'h1);

    read_burst(7'h08, 8'd2, 2'b11, 0);
    check_read("bad_arburst", 7'h08, 8'd2, 2'b11);

    // Reset while the third beat of an 8-beat read is being presented.
    bus.ARADDR = 7'h00; bus.ARLEN = 8'd7; bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
    cnt = 0;
    while (!bus.ARREADY && cnt < 50) begin step(); cnt++; end
    if (cnt >= 50) report_timeout("rst_ar_handshake");
    step();
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    n = 0; cnt = 0;
    while (n < 2 && cnt < 50) begin
      if (bus.RVALID) n++;
      step();
      cnt++;
    end
    if (cnt >= 50) report_timeout("rst_beats");
    checkOutput("rst_beat3_data", bus.RDATA, model_mem[2]);
    ARESET = 1'b1; bus.RREADY = 1'b0;
    step();
    checkOutput("midrst_rvalid", 32'(bus.RVALID), 32'h0);
    checkOutput("midrst_rdata", bus.RDATA, 32'h0);
    checkOutput("midrst_arready", 32'(bus.ARREADY), 32'h0);
    ARESET = 1'b0;
    step();
    checkOutput("postrst_arready", 32'(bus.ARREADY), 32'h1);
    checkOutput("postrst_rvalid", 32'(bus.RVALID), 32'h0);
    read_burst(7'h00, 8'd7, 2'b01, 0);
    check_read("postrst_rd", 7'h00, 8'd7, 2'b01);

    for (int k = 0; k < 24; k++) begin
      bt = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      l  = 8'($urandom_range(0, 7));
      a  = {5'($urandom_range(0, 31)), 2'b00};
      s  = 4'($urandom_range(0, 15));
      wb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(l))) : int'(l);
      for (int i = 0; i <= int'(l); i++) wbeats[i] = $urandom;
      write_burst(a, l, bt, s, wb, resp);
      model_write(a, l, bt, s, wb, mresp);
      checkOutput($sformatf("rand%0d_bresp", k), 32'(resp), 32'(mresp));
      bt = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
      l  = 8'($urandom_range(0, 9));
      a  = {5'($urandom_range(0, 31)), 2'b00};
      read_burst(a, l, bt, 2);
      check_read($sformatf("rand%0d_rd", k), a, l, bt);
    end

    read_burst(7'h00, 8'd31, 2'b01, 2);
    check_read("final_dump", 7'h00, 8'd31, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
